config_tp_pio_key: RTL and testbench

//  Avalon-MM slave input PIO for push-buttons/switches; the input-side counterpart of the LED output PIO.

---
 rtl/config_tp_pio_key_pkg.sv | 20 ++
 rtl/config_tp_pio_key_sync_edge.sv | 47 ++++
 rtl/config_tp_pio_key.sv | 80 ++++++++
 tb/tb_config_tp_pio_key.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/config_tp_pio_key_pkg.sv
// Shared definitions for the key/switch input PIO: register offsets,
// edge-type encodings and the bus write-strobe helper.
package config_tp_pio_key_pkg;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } pio_reg_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic logic bus_write(input logic cs, input logic wr_n);
        return cs & ~wr_n;
    endfunction

endpackage

// File: rtl/config_tp_pio_key_sync_edge.sv
// Multi-stage synchroniser for the PIO inputs plus a one-cycle-delayed copy
// used to produce a single-cycle edge pulse per bit.
module pio_sync_edge
    import config_tp_pio_key_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;

    // Synchroniser shift chain and previous-value register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {(SYNC_STAGES*WIDTH){1'b0}};
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = o_sync & ~r_prev;
    assign w_fall = ~o_sync & r_prev;

    // Qualify the raw transitions by the configured edge type
    always_comb begin
        o_edge = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            EDGE_RISING:  o_edge = w_rise;
            EDGE_FALLING: o_edge = w_fall;
            default:      o_edge = w_rise | w_fall;
        endcase
    end

endmodule

// File: rtl/config_tp_pio_key.sv
// Avalon-MM input PIO for keys/switches: synchronised DATA, sticky per-bit
// edge capture with write-1-to-clear, and a maskable level interrupt.
module config_tp_pio_key
    import config_tp_pio_key_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 1,
    parameter logic [31:0] RESET_MASK  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic             w_wr;
    logic             w_mask_we;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] w_cap_nxt;
    logic             w_unused_wdata;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_sync),
        .o_edge  (w_edge)
    );

    assign w_wr           = bus_write(chipselect, write_n);
    assign w_mask_we      = w_wr && (address == REG_IRQMASK);
    assign w_cap_clr      = (w_wr && (address == REG_EDGECAP)) ? writedata[WIDTH-1:0]
                                                              : {WIDTH{1'b0}};
    // New edge is OR-ed in after the clear so a coincident edge is never lost
    assign w_cap_nxt      = (r_edge_cap & ~w_cap_clr) | w_edge;
    assign w_unused_wdata = ^writedata;

    // Interrupt mask and sticky edge-capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= RESET_MASK[WIDTH-1:0];
            r_edge_cap <= {WIDTH{1'b0}};
        end else begin
            if (w_mask_we) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end else begin
                r_irq_mask <= r_irq_mask;
            end
            r_edge_cap <= w_cap_nxt;
        end
    end

    // Zero-wait-state read mux; unused offsets and upper bits read as zero
    always_comb begin
        readdata = 32'h0000_0000;
        case (pio_reg_e'(address))
            REG_DATA:    readdata[WIDTH-1:0] = w_sync;
            REG_IRQMASK: readdata[WIDTH-1:0] = r_irq_mask;
            REG_EDGECAP: readdata[WIDTH-1:0] = r_edge_cap;
            default:     readdata = 32'h0000_0000;
        endcase
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_config_tp_pio_key.sv
// Scoreboard bench for config_tp_pio_key (WIDTH=4, SYNC_STAGES=2, falling edge).
// Read requests push an expected {readdata, irq}; a monitor pops and compares.
module tb_config_tp_pio_key;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic        rd_req;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    config_tp_pio_key #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (1),
        .RESET_MASK  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Monitor: compare each presented read against the scoreboard head
    always @(negedge clk) begin
        if (rd_req) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: addr=%0d got data=%h irq=%b, expected none",
                         address, readdata, irq);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({irq, readdata} !== {e.irq, e.data} || address !== e.addr) begin
                    n_bad++;
                    $display("FAIL %s: addr=%0d got data=%h irq=%b, expected addr=%0d data=%h irq=%b",
                             e.name, address, readdata, irq, e.addr, e.data, e.irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic q, input string nm);
        exp_t e;
        e.addr = a; e.data = d; e.irq = q; e.name = nm;
        sb_q.push_back(e);
        address = a; chipselect = 1'b1; write_n = 1'b1; rd_req = 1'b1;
        tick(1);
        chipselect = 1'b0; rd_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 4'hF; rd_req = 1'b0;
        tick(2);
        // Reset state
        rd(2'd0, 32'h0, 1'b0, "rst_data");
        rd(2'd2, 32'h0, 1'b0, "rst_mask");
        rd(2'd3, 32'h0, 1'b0, "rst_edgecap");
        reset_n = 1'b1;
        tick(4);
        rd(2'd0, 32'hF, 1'b0, "idle_data");
        rd(2'd1, 32'h0, 1'b0, "rsvd_read");
        rd(2'd3, 32'h0, 1'b0, "no_cap_on_fill");

        // Latency: F->E sampled at edge N
        in_port = 4'hE;
        rd(2'd0, 32'hF, 1'b0, "lat_data_pre");
        rd(2'd0, 32'hF, 1'b0, "lat_data_n");
        rd(2'd0, 32'hE, 1'b0, "lat_data_n1");
        rd(2'd3, 32'h1, 1'b0, "lat_cap_n2");
        in_port = 4'hF;
        tick(3);
        rd(2'd3, 32'h1, 1'b0, "rise_ignored");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, 1'b0, "clear_bit0");

        // Masked capture on bit2, then unmask
        in_port = 4'hB;
        rd(2'd3, 32'h0, 1'b0, "mask_cap_m");
        rd(2'd3, 32'h0, 1'b0, "mask_cap_m0");
        rd(2'd3, 32'h0, 1'b0, "mask_cap_m1");
        rd(2'd3, 32'h4, 1'b0, "mask_cap_m2");
        in_port = 4'hF;
        wr(2'd2, 32'h4);
        rd(2'd3, 32'h4, 1'b1, "unmask_irq");
        rd(2'd2, 32'h4, 1'b1, "mask_readback");

        // W1C behaviour
        in_port = 4'hE; tick(3); in_port = 4'hF; tick(3);
        rd(2'd3, 32'h5, 1'b1, "w1c_pre");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h4, 1'b1, "w1c_one");
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h4, 1'b1, "w1c_zero");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h0, 1'b0, "w1c_all");

        // Collision: clear bit0 on the same edge that captures a new bit0 edge
        wr(2'd2, 32'h1);
        in_port = 4'hE; tick(3); in_port = 4'hF; tick(3);
        rd(2'd3, 32'h1, 1'b1, "coll_pre");
        in_port = 4'hE;
        tick(2);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h1, 1'b1, "coll_set_wins");
        in_port = 4'hF; tick(3);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, 1'b0, "coll_later_clear");

        // Register map
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd2, 32'h1, 1'b0, "map_mask_kept");
        rd(2'd3, 32'h0, 1'b0, "map_cap_kept");
        rd(2'd0, 32'hF, 1'b0, "map_data");
        rd(2'd1, 32'h0, 1'b0, "map_rsvd");
        wr(2'd2, 32'hFFFF_FFF0);
        rd(2'd2, 32'h0, 1'b0, "map_upper_ignored");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'hF, 1'b0, "map_upper_zero");

        // Reset mid-run with all bits captured
        in_port = 4'h0; tick(3); in_port = 4'hF; tick(3);
        rd(2'd3, 32'hF, 1'b1, "all_cap");
        reset_n = 1'b0;
        rd(2'd0, 32'h0, 1'b0, "midrst_data");
        rd(2'd3, 32'h0, 1'b0, "midrst_cap");
        rd(2'd2, 32'h0, 1'b0, "midrst_mask");
        reset_n = 1'b1;
        tick(4);
        rd(2'd3, 32'h0, 1'b0, "post_rst_cap");
        rd(2'd0, 32'hF, 1'b0, "post_rst_data");

        tick(2);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
